// File: rtl/nmr_cpmg_sequencer.sv
// CPMG train sequencer: drives one pulse bit streamer through a 90-deg segment
// followed by necho 180-deg segments, reloading the streamer words per segment.
module nmr_cpmg_sequencer #(
  parameter int IDLY_WIDTH  = 32,
  parameter int PLS_WIDTH   = 32,
  parameter int EDLY_WIDTH  = 32,
  parameter int NECHO_WIDTH = 16,
  parameter int GAP_CYC     = 2,
  parameter int TO_CYC      = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   GO,
  input  logic                   ABORT,
  input  logic [IDLY_WIDTH-1:0]  p90_idly,
  input  logic [PLS_WIDTH-1:0]   p90_pls,
  input  logic [EDLY_WIDTH-1:0]  p90_edly,
  input  logic [IDLY_WIDTH-1:0]  p180_idly,
  input  logic [PLS_WIDTH-1:0]   p180_pls,
  input  logic [EDLY_WIDTH-1:0]  p180_edly,
  input  logic [NECHO_WIDTH-1:0] necho,
  output logic                   bs_start,
  input  logic                   bs_done,
  output logic [IDLY_WIDTH-1:0]  bs_idly,
  output logic [PLS_WIDTH-1:0]   bs_pls,
  output logic [EDLY_WIDTH-1:0]  bs_edly,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERR,
  output logic [NECHO_WIDTH-1:0] echo_idx,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_GAP   = 3'd4,
    S_FIN   = 3'd5,
    S_TOERR = 3'd6,
    S_DRAIN = 3'd7
  } state_t;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CYC - 1);

  state_t state, state_d;
  logic [CNT_W-1:0] cnt;
  logic go_q, go_rise, accept;
  logic seg_180;
  logic [NECHO_WIDTH-1:0] next_idx;

  logic [IDLY_WIDTH-1:0]  sh_p90_idly, sh_p180_idly;
  logic [PLS_WIDTH-1:0]   sh_p90_pls,  sh_p180_pls;
  logic [EDLY_WIDTH-1:0]  sh_p90_edly, sh_p180_edly;
  logic [NECHO_WIDTH-1:0] sh_necho;

  assign go_rise  = GO & ~go_q;
  assign next_idx = echo_idx + NECHO_WIDTH'(seg_180);

  // Streamer handshake: bs_start rises only with bs_done high and stays high until
  // bs_done has fallen and risen again; bs_start then drops for at least GAP + LOAD.
  assign bs_start  = (state == S_ARM) || (state == S_RUN);
  assign DONE      = (state == S_FIN);
  assign BUSY      = (state == S_LOAD) || (state == S_ARM) || (state == S_RUN) ||
                     (state == S_GAP)  || (state == S_FIN);
  assign dbg_state = state;

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (go_rise && !ABORT) begin
          state_d = S_LOAD;
          accept  = 1'b1;
        end
      end
      S_LOAD:  if (cnt == GAP_LAST) state_d = S_ARM;
      S_ARM: begin
        if (!bs_done)            state_d = S_RUN;
        else if (cnt == TO_LAST) state_d = S_TOERR;
      end
      S_RUN:   if (bs_done) state_d = S_GAP;
      S_GAP: begin
        // Full-width compare against the shadow count, so all-ones necho never wraps.
        if (seg_180 ? (next_idx == sh_necho) : (sh_necho == '0)) state_d = S_FIN;
        else                                                     state_d = S_LOAD;
      end
      S_FIN:   state_d = S_IDLE;
      S_TOERR: state_d = S_IDLE;
      S_DRAIN: if (bs_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (ABORT && state != S_IDLE && state != S_DRAIN) state_d = S_DRAIN;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= '0;
      go_q  <= 1'b0;
    end else begin
      state <= state_d;
      go_q  <= GO;
      cnt   <= (state_d != state) ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh_p90_idly  <= '0;
      sh_p90_pls   <= '0;
      sh_p90_edly  <= '0;
      sh_p180_idly <= '0;
      sh_p180_pls  <= '0;
      sh_p180_edly <= '0;
      sh_necho     <= '0;
      seg_180      <= 1'b0;
      echo_idx     <= '0;
      ERR          <= 1'b0;
      bs_idly      <= '0;
      bs_pls       <= '0;
      bs_edly      <= '0;
    end else begin
      if (accept) begin
        sh_p90_idly  <= p90_idly;
        sh_p90_pls   <= p90_pls;
        sh_p90_edly  <= p90_edly;
        sh_p180_idly <= p180_idly;
        sh_p180_pls  <= p180_pls;
        sh_p180_edly <= p180_edly;
        sh_necho     <= necho;
        seg_180      <= 1'b0;
        echo_idx     <= '0;
        ERR          <= 1'b0;
      end
      if (state == S_GAP && !ABORT) begin
        echo_idx <= next_idx;
        seg_180  <= 1'b1;
      end
      if (state_d == S_TOERR && state != S_TOERR) ERR <= 1'b1;
      // Words latch on the first LOAD cycle and are stable through ARM and RUN.
      if (state == S_LOAD) begin
        bs_idly <= seg_180 ? sh_p180_idly : sh_p90_idly;
        bs_pls  <= seg_180 ? sh_p180_pls  : sh_p90_pls;
        bs_edly <= seg_180 ? sh_p180_edly : sh_p90_edly;
      end
    end
  end

endmodule

// File: tb/tb_nmr_cpmg_sequencer.sv
// Directed bench for nmr_cpmg_sequencer with a behavioural bit streamer and a
// scoreboard of expected per-segment pulse/delay words.
module tb_nmr_cpmg_sequencer;

  localparam int W  = 32;
  localparam int NW = 4;
  localparam int TO = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic GO = 1'b0, ABORT = 1'b0;
  logic [W-1:0] p90_idly = '0, p90_pls = '0, p90_edly = '0;
  logic [W-1:0] p180_idly = '0, p180_pls = '0, p180_edly = '0;
  logic [NW-1:0] necho = '0;
  logic bs_start, bs_done;
  logic [W-1:0] bs_idly, bs_pls, bs_edly;
  logic BUSY, DONE, ERR;
  logic [NW-1:0] echo_idx;
  logic [2:0] dbg_state;

  nmr_cpmg_sequencer #(
    .IDLY_WIDTH(W), .PLS_WIDTH(W), .EDLY_WIDTH(W),
    .NECHO_WIDTH(NW), .GAP_CYC(2), .TO_CYC(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .GO(GO), .ABORT(ABORT),
    .p90_idly(p90_idly), .p90_pls(p90_pls), .p90_edly(p90_edly),
    .p180_idly(p180_idly), .p180_pls(p180_pls), .p180_edly(p180_edly),
    .necho(necho), .bs_start(bs_start), .bs_done(bs_done),
    .bs_idly(bs_idly), .bs_pls(bs_pls), .bs_edly(bs_edly),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .echo_idx(echo_idx),
    .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  // Streamer model: idle with DONE high; a START seen while idle drops DONE for a
  // random run length, then DONE returns and waits for START to drop.
  logic tie_high = 1'b0;
  logic active;
  int   run_cnt;
  logic [W-1:0] obs_pls[$];
  logic [W-1:0] obs_idly[$];

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      bs_done <= 1'b1;
      active  <= 1'b0;
      run_cnt <= 0;
    end else if (!active) begin
      if (bs_start && bs_done && !tie_high) begin
        active  <= 1'b1;
        bs_done <= 1'b0;
        run_cnt <= $urandom_range(2, 6);
        obs_pls.push_back(bs_pls);
        obs_idly.push_back(bs_idly);
      end
    end else if (!bs_done) begin
      if (run_cnt == 0) bs_done <= 1'b1;
      else              run_cnt <= run_cnt - 1;
    end else if (!bs_start) begin
      active <= 1'b0;
    end
  end

  int done_cnt = 0, start_hi_cnt = 0;
  always @(negedge CLK) begin
    done_cnt     <= done_cnt + int'(DONE);
    start_hi_cnt <= start_hi_cnt + int'(bs_start);
  end

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_idly_q[$];
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic set_words(input logic [W-1:0] a_pls, input logic [W-1:0] a_idly,
                           input logic [W-1:0] b_pls, input logic [W-1:0] b_idly,
                           input logic [NW-1:0] n);
    p90_pls = a_pls; p90_idly = a_idly; p90_edly = 4;
    p180_pls = b_pls; p180_idly = b_idly; p180_edly = 4;
    necho = n;
  endtask

  task automatic push_exp(input int nseg);
    for (int i = 0; i < nseg; i++) begin
      exp_q.push_back(i == 0 ? p90_pls : p180_pls);
      exp_idly_q.push_back(i == 0 ? p90_idly : p180_idly);
    end
  endtask

  task automatic pulse_go(input string tag, input bit hold);
    GO = 1'b1;
    tick();
    chk({tag, "_busy_after_go"}, BUSY, 1);
    if (!hold) GO = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(dbg_state == 3'd0 && !BUSY) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk({tag, "_idle_timeout"}, 1, 0);
  endtask

  task automatic wait_run(input string tag, input logic [NW-1:0] idx);
    int n;
    n = 0;
    while (!(bs_start && !bs_done && echo_idx == idx) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk({tag, "_run_timeout"}, 1, 0);
  endtask

  task automatic check_segs(input string tag, input int base);
    chk({tag, "_seg_count"}, obs_pls.size() - base, exp_q.size());
    for (int k = 0; k < obs_pls.size() - base; k++) begin
      if (exp_q.size() == 0) break;
      chk({tag, "_seg_pls"}, obs_pls[base + k], exp_q.pop_front());
      chk({tag, "_seg_idly"}, obs_idly[base + k], exp_idly_q.pop_front());
    end
    exp_q.delete();
    exp_idly_q.delete();
  endtask

  initial begin
    int base, d0, s0;

    repeat (3) tick();
    chk("rst_bs_start", bs_start, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_echo_idx", echo_idx, 0);
    chk("rst_bs_pls", bs_pls, 0);
    chk("rst_bs_idly", bs_idly, 0);
    RST = 1'b0;
    repeat (2) tick();

    // Basic train: necho=3
    set_words(5, 4, 10, 4, 3);
    base = obs_pls.size(); d0 = done_cnt;
    push_exp(4);
    pulse_go("t3", 0);
    wait_idle("t3");
    tick();
    check_segs("t3", base);
    chk("t3_done_pulses", done_cnt - d0, 1);
    chk("t3_echo_idx", echo_idx, 3);
    chk("t3_busy_low", BUSY, 0);
    chk("t3_bs_pls_held", bs_pls, 10);

    // necho=0: one 90-deg segment only
    set_words(7, 9, 11, 13, 0);
    base = obs_pls.size(); d0 = done_cnt;
    push_exp(1);
    pulse_go("t0", 0);
    wait_idle("t0");
    tick();
    check_segs("t0", base);
    chk("t0_done_pulses", done_cnt - d0, 1);
    chk("t0_echo_idx", echo_idx, 0);

    // Inputs change mid-train, GO held high throughout
    set_words(6, 3, 12, 8, 2);
    base = obs_pls.size(); d0 = done_cnt;
    push_exp(3);
    pulse_go("tchg", 1);
    wait_run("tchg", 1);
    p180_pls = 99; p90_pls = 99; necho = 0;
    wait_idle("tchg");
    repeat (20) tick();
    chk("tchg_no_retrigger", BUSY, 0);
    chk("tchg_done_pulses", done_cnt - d0, 1);
    chk("tchg_echo_idx", echo_idx, 2);
    check_segs("tchg", base);
    GO = 1'b0;
    tick();

    // Streamer never drops DONE: timeout
    tie_high = 1'b1;
    set_words(5, 4, 10, 4, 2);
    d0 = done_cnt; s0 = start_hi_cnt;
    pulse_go("tto", 0);
    wait_idle("tto");
    chk("tto_err", ERR, 1);
    chk("tto_busy", BUSY, 0);
    chk("tto_no_done", done_cnt - d0, 0);
    chk("tto_arm_cycles", start_hi_cnt - s0, TO);
    tie_high = 1'b0;
    repeat (2) tick();
    chk("tto_err_sticky", ERR, 1);
    set_words(21, 22, 23, 24, 0);
    base = obs_pls.size();
    push_exp(1);
    pulse_go("tclr", 0);
    chk("tclr_err_cleared", ERR, 0);
    wait_idle("tclr");
    check_segs("tclr", base);

    // ABORT during the second 180-deg RUN
    set_words(5, 4, 10, 4, 4);
    base = obs_pls.size(); d0 = done_cnt;
    push_exp(3);
    pulse_go("tab", 0);
    wait_run("tab", 1);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("tab_start_low", bs_start, 0);
    wait_idle("tab");
    repeat (3) tick();
    chk("tab_state_idle", dbg_state, 0);
    chk("tab_no_done", done_cnt - d0, 0);
    chk("tab_err", ERR, 0);
    check_segs("tab", base);

    // Reset asserted mid-RUN
    set_words(5, 4, 10, 4, 2);
    pulse_go("trst", 0);
    wait_run("trst", 0);
    #2 RST = 1'b1;
    #1;
    chk("trst_bs_start", bs_start, 0);
    chk("trst_busy", BUSY, 0);
    chk("trst_echo_idx", echo_idx, 0);
    chk("trst_bs_pls", bs_pls, 0);
    chk("trst_err", ERR, 0);
    repeat (2) tick();
    RST = 1'b0;
    repeat (2) tick();
    set_words(31, 2, 32, 3, 1);
    base = obs_pls.size(); d0 = done_cnt;
    push_exp(2);
    pulse_go("tpost", 0);
    wait_idle("tpost");
    tick();
    check_segs("tpost", base);
    chk("tpost_done_pulses", done_cnt - d0, 1);
    chk("tpost_echo_idx", echo_idx, 1);

    // necho at all-ones: no echo_idx wrap
    set_words(1, 1, 2, 2, {NW{1'b1}});
    base = obs_pls.size(); d0 = done_cnt;
    push_exp(1 + (1 << NW) - 1);
    pulse_go("tmax", 0);
    wait_idle("tmax");
    tick();
    check_segs("tmax", base);
    chk("tmax_echo_idx", echo_idx, (1 << NW) - 1);
    chk("tmax_done_pulses", done_cnt - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
